// File: rtl/draw_pkg.sv
// Shared constants for the draw sequencer: packed draw-word layout, screen
// limits, mux select codes, FSM state type and the per-frame sprite order.
package draw_pkg;

    // Packed draw word {x[17:10], y[9:3], colour[2:0]}
    localparam int X_W    = 8;
    localparam int Y_W    = 7;
    localparam int C_W    = 3;
    localparam int WORD_W = X_W + Y_W + C_W;
    localparam int X_LSB  = Y_W + C_W;
    localparam int Y_LSB  = C_W;
    localparam int C_LSB  = 0;

    // Visible screen limits (inclusive)
    localparam int X_MAX = 159;
    localparam int Y_MAX = 119;

    // Raster counter width, enough for sprite sizes up to 16
    localparam int CNT_W = 4;

    // Source mux select codes
    localparam int SEL_W = 3;
    localparam logic [SEL_W-1:0] SEL_EGG1     = 3'b000;
    localparam logic [SEL_W-1:0] SEL_EGG2     = 3'b001;
    localparam logic [SEL_W-1:0] SEL_EGG3     = 3'b010;
    localparam logic [SEL_W-1:0] SEL_BLACK    = 3'b011;
    localparam logic [SEL_W-1:0] SEL_PLYR     = 3'b100;
    localparam logic [SEL_W-1:0] SEL_GAMEOVER = 3'b110;

    // Sprites per frame, minus one (index of the final sprite)
    localparam logic [2:0] LAST_IDX_NORMAL   = 3'd4;
    localparam logic [2:0] LAST_IDX_GAMEOVER = 3'd0;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        LATCH,
        DRAW,
        DONE
    } state_t;

    // Select code of the idx-th sprite drawn in a frame. The black clear
    // block goes first so the moving sprites are painted over it.
    function automatic logic [SEL_W-1:0] sel_code(input logic game_over,
                                                  input logic [2:0] idx);
        logic [SEL_W-1:0] code;
        if (game_over) begin
            code = SEL_GAMEOVER;
        end else begin
            case (idx)
                3'd0:    code = SEL_BLACK;
                3'd1:    code = SEL_EGG1;
                3'd2:    code = SEL_EGG2;
                3'd3:    code = SEL_EGG3;
                default: code = SEL_PLYR;
            endcase
        end
        return code;
    endfunction

endpackage

// File: rtl/sprite_scanner.sv
// Raster walker for one sprite: holds the latched base position and the
// dx/dy counters, and reports the coordinates, in-bounds flag and
// last-pixel flag. The coordinate outputs describe the pixel the counters
// will hold after the coming edge, so the owner can register them straight
// into its pixel outputs without an extra pipeline stage.
module sprite_scanner
    import draw_pkg::*;
#(
    parameter int SPRITE_W = 4,
    parameter int SPRITE_H = 4,
    parameter int X_LIMIT  = 159,
    parameter int Y_LIMIT  = 119
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           load,
    input  logic           advance,
    input  logic [X_W-1:0] base_x_in,
    input  logic [Y_W-1:0] base_y_in,
    output logic [X_W:0]   pix_x,
    output logic [Y_W:0]   pix_y,
    output logic           in_bounds,
    output logic           last_pixel
);

    logic [X_W-1:0]   base_x_q, base_x_d;
    logic [Y_W-1:0]   base_y_q, base_y_d;
    logic [CNT_W-1:0] dx_q, dx_d;
    logic [CNT_W-1:0] dy_q, dy_d;

    // Next base/counter values: load restarts the raster, advance steps it
    always_comb begin
        base_x_d = base_x_q;
        base_y_d = base_y_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        if (load) begin
            base_x_d = base_x_in;
            base_y_d = base_y_in;
            dx_d     = '0;
            dy_d     = '0;
        end else if (advance) begin
            if (dx_q == CNT_W'(SPRITE_W - 1)) begin
                dx_d = '0;
                dy_d = (dy_q == CNT_W'(SPRITE_H - 1)) ? '0 : dy_q + 1'b1;
            end else begin
                dx_d = dx_q + 1'b1;
            end
        end
    end

    // Base and raster counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            base_x_q <= '0;
            base_y_q <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
        end else begin
            base_x_q <= base_x_d;
            base_y_q <= base_y_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
        end
    end

    // One extra bit on each sum so off-screen pixels are detected, not wrapped
    always_comb begin
        pix_x      = (X_W + 1)'(base_x_d) + (X_W + 1)'(dx_d);
        pix_y      = (Y_W + 1)'(base_y_d) + (Y_W + 1)'(dy_d);
        in_bounds  = (pix_x <= (X_W + 1)'(X_LIMIT)) && (pix_y <= (Y_W + 1)'(Y_LIMIT));
        last_pixel = (dx_q == CNT_W'(SPRITE_W - 1)) && (dy_q == CNT_W'(SPRITE_H - 1));
    end

endmodule

// File: rtl/draw_sequencer.sv
// Per-frame draw sequencer: walks the source mux through every active
// sprite, latches each packed draw word and rasterises a SPRITE_W x SPRITE_H
// block into the VGA adapter, one pixel per clock.
module draw_sequencer #(
    parameter int SPRITE_W = 4,
    parameter int SPRITE_H = 4,
    parameter int X_MAX    = draw_pkg::X_MAX,
    parameter int Y_MAX    = draw_pkg::Y_MAX
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        game_over,
    input  logic [draw_pkg::WORD_W-1:0] mux_out,
    output logic [draw_pkg::SEL_W-1:0]  mux_select,
    output logic [draw_pkg::X_W-1:0]    x_vga,
    output logic [draw_pkg::Y_W-1:0]    y_vga,
    output logic [draw_pkg::C_W-1:0]    colour_vga,
    output logic                        plot,
    output logic                        busy,
    output logic                        done
);

    import draw_pkg::*;

    state_t           state_q, state_d;
    logic             game_over_q, game_over_d;
    logic [2:0]       index_q, index_d;
    logic [C_W-1:0]   col_q, col_d;
    logic [SEL_W-1:0] mux_select_q, mux_select_d;
    logic [X_W-1:0]   x_vga_q, x_vga_d;
    logic [Y_W-1:0]   y_vga_q, y_vga_d;
    logic [C_W-1:0]   colour_vga_q, colour_vga_d;
    logic             plot_q, plot_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             scan_load;
    logic             scan_advance;
    logic [X_W:0]     scan_x;
    logic [Y_W:0]     scan_y;
    logic             scan_in_bounds;
    logic             scan_last;
    logic [2:0]       last_idx;

    // mux_out is only looked at in LATCH; the scanner ignores it otherwise
    assign scan_load    = (state_q == LATCH);
    assign scan_advance = (state_q == DRAW) && !scan_last;
    assign last_idx     = game_over_q ? LAST_IDX_GAMEOVER : LAST_IDX_NORMAL;

    sprite_scanner #(
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H),
        .X_LIMIT  (X_MAX),
        .Y_LIMIT  (Y_MAX)
    ) u_scanner (
        .clock      (clock),
        .reset      (reset),
        .load       (scan_load),
        .advance    (scan_advance),
        .base_x_in  (mux_out[X_LSB +: X_W]),
        .base_y_in  (mux_out[Y_LSB +: Y_W]),
        .pix_x      (scan_x),
        .pix_y      (scan_y),
        .in_bounds  (scan_in_bounds),
        .last_pixel (scan_last)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        game_over_d  = game_over_q;
        index_d      = index_q;
        col_d        = col_q;
        mux_select_d = mux_select_q;
        x_vga_d      = x_vga_q;
        y_vga_d      = y_vga_q;
        colour_vga_d = colour_vga_q;
        plot_d       = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    game_over_d  = game_over;
                    index_d      = 3'd0;
                    mux_select_d = sel_code(game_over, 3'd0);
                    busy_d       = 1'b1;
                    state_d      = SELECT;
                end
            end
            SELECT: begin
                // One cycle for the mux output to settle on the new select
                state_d = LATCH;
            end
            LATCH: begin
                // The first pixel goes out in the cycle right after the latch
                col_d        = mux_out[C_LSB +: C_W];
                x_vga_d      = scan_x[X_W-1:0];
                y_vga_d      = scan_y[Y_W-1:0];
                colour_vga_d = mux_out[C_LSB +: C_W];
                plot_d       = scan_in_bounds;
                state_d      = DRAW;
            end
            DRAW: begin
                if (scan_last) begin
                    if (index_q == last_idx) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        index_d      = index_q + 3'd1;
                        mux_select_d = sel_code(game_over_q, index_q + 3'd1);
                        state_d      = SELECT;
                    end
                end else begin
                    // Clipped pixels keep their cycle so frame timing is fixed
                    x_vga_d      = scan_x[X_W-1:0];
                    y_vga_d      = scan_y[Y_W-1:0];
                    colour_vga_d = col_q;
                    plot_d       = scan_in_bounds;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            game_over_q  <= 1'b0;
            index_q      <= 3'd0;
            col_q        <= '0;
            mux_select_q <= '0;
            x_vga_q      <= '0;
            y_vga_q      <= '0;
            colour_vga_q <= '0;
            plot_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            game_over_q  <= game_over_d;
            index_q      <= index_d;
            col_q        <= col_d;
            mux_select_q <= mux_select_d;
            x_vga_q      <= x_vga_d;
            y_vga_q      <= y_vga_d;
            colour_vga_q <= colour_vga_d;
            plot_q       <= plot_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign mux_select = mux_select_q;
    assign x_vga      = x_vga_q;
    assign y_vga      = y_vga_q;
    assign colour_vga = colour_vga_q;
    assign plot       = plot_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench for draw_sequencer: a table-driven source mux model, a
// scoreboard of expected pixels (with their cycle) built when each frame is
// launched, and per-cycle checks of busy, done and mux_select.
module tb_draw_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        game_over;
    logic [17:0] mux_out;
    logic [2:0]  mux_select;
    logic [7:0]  x_vga;
    logic [6:0]  y_vga;
    logic [2:0]  colour_vga;
    logic        plot;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    // Source mux model: word per select code; optionally garbage outside LATCH
    logic [17:0] tbl [8];
    logic        tog_mode  = 1'b0;
    logic        mux_latch = 1'b0;
    logic [17:0] garbage   = '0;

    assign mux_out = (tog_mode && !mux_latch) ? garbage : tbl[mux_select];

    typedef struct {
        int          cyc;
        logic [17:0] pix;
    } exp_t;
    exp_t sb[$];

    always #5 clock = ~clock;

    draw_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .game_over  (game_over),
        .mux_out    (mux_out),
        .mux_select (mux_select),
        .x_vga      (x_vga),
        .y_vga      (y_vga),
        .colour_vga (colour_vga),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] pk(input int x, input int y, input int c);
        return {8'(x), 7'(y), 3'(c)};
    endfunction

    function automatic logic [2:0] code(input bit go, input int i);
        if (go) return 3'b110;
        case (i)
            0:       return 3'b011;
            1:       return 3'b000;
            2:       return 3'b001;
            3:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    // Launch one frame (start sampled at edge 0), watch cycles 1..win.
    // ra/rb: cycles in which start is pulsed again; rst_at: cycle with reset.
    task automatic run_frame(input string name, input bit go, input bit tog,
                             input int ra, input int rb, input int rst_at,
                             input int win, input int exp_plots);
        int          nsp;
        int          done_exp;
        int          last_busy;
        int          nplots;
        int          ndone;
        int          done_at;
        int          busy_bad;
        int          sel_bad;
        int          si;
        int          sx;
        int          sy;
        int          c;
        logic [17:0] w;
        logic [2:0]  sel_exp;
        exp_t        e;

        nsp       = go ? 1 : 5;
        done_exp  = (rst_at >= 0) ? -1 : (go ? 19 : 91);
        last_busy = (rst_at >= 0) ? rst_at : done_exp - 1;
        nplots    = 0;
        ndone     = 0;
        done_at   = -1;
        busy_bad  = 0;
        sel_bad   = 0;

        // Expected pixels in raster order with the cycle each should appear in
        sb.delete();
        for (int i = 0; i < nsp; i++) begin
            w = tbl[code(go, i)];
            for (int dy = 0; dy < 4; dy++) begin
                for (int dx = 0; dx < 4; dx++) begin
                    sx = int'(w[17:10]) + dx;
                    sy = int'(w[9:3]) + dy;
                    c  = 3 + 18 * i + 4 * dy + dx;
                    if (sx <= 159 && sy <= 119 && (rst_at < 0 || c <= rst_at))
                        sb.push_back('{c, pk(sx, sy, int'(w[2:0]))});
                end
            end
        end

        @(negedge clock);
        start     = 1'b1;
        game_over = go;
        tog_mode  = tog;
        mux_latch = 1'b0;

        for (int r = 1; r <= win; r++) begin
            @(negedge clock);
            start     = 1'b0;
            game_over = 1'($urandom);
            garbage   = 18'($urandom);
            mux_latch = (r >= 2) && ((r - 2) % 18 == 0);

            if (plot === 1'b1) begin
                nplots++;
                if (sb.size() == 0) begin
                    chk({name, " extra_plot_cycle"}, 32'(r), 32'(0));
                end else begin
                    e = sb.pop_front();
                    chk({name, " plot_cycle"}, 32'(r), 32'(e.cyc));
                    chk({name, " plot_pixel"}, 32'({x_vga, y_vga, colour_vga}), 32'(e.pix));
                end
            end
            if (done === 1'b1) begin
                ndone++;
                done_at = r;
            end
            if (busy !== (r <= last_busy)) busy_bad++;

            si = (r - 1) / 18;
            if (si > nsp - 1) si = nsp - 1;
            sel_exp = (rst_at >= 0 && r > rst_at) ? 3'b000 : code(go, si);
            if (mux_select !== sel_exp) sel_bad++;

            if (rst_at >= 0 && r == rst_at + 1) begin
                chk({name, " post_reset_plot"}, 32'(plot), 32'(0));
                chk({name, " post_reset_busy"}, 32'(busy), 32'(0));
                chk({name, " post_reset_pixel"}, 32'({x_vga, y_vga, colour_vga}), 32'(0));
            end

            start = (r == ra) || (r == rb);
            reset = (r == rst_at);
        end
        start    = 1'b0;
        reset    = 1'b0;
        tog_mode = 1'b0;

        chk({name, " plot_count"}, 32'(nplots), 32'(exp_plots));
        chk({name, " done_count"}, 32'(ndone), 32'((done_exp < 0) ? 0 : 1));
        chk({name, " done_cycle"}, 32'(done_at), 32'(done_exp));
        chk({name, " busy_bad_cycles"}, 32'(busy_bad), 32'(0));
        chk({name, " select_bad_cycles"}, 32'(sel_bad), 32'(0));
        chk({name, " pixels_missing"}, 32'(sb.size()), 32'(0));
        $display("frame %s: plots=%0d done_cycle=%0d", name, nplots, done_at);
    endtask

    initial begin
        tbl[0] = pk(10, 20, 6);
        tbl[1] = pk(50, 60, 2);
        tbl[2] = pk(70, 60, 2);
        tbl[3] = pk(0, 0, 0);
        tbl[4] = pk(80, 100, 5);
        tbl[5] = pk(1, 2, 3);
        tbl[6] = pk(40, 50, 4);
        tbl[7] = pk(3, 2, 1);

        // Reset held two cycles with random inputs
        reset     = 1'b1;
        start     = 1'($urandom);
        game_over = 1'($urandom);
        repeat (2) begin
            @(negedge clock);
            start     = 1'($urandom);
            game_over = 1'($urandom);
        end
        chk("reset mux_select", 32'(mux_select), 32'(0));
        chk("reset pixel", 32'({x_vga, y_vga, colour_vga}), 32'(0));
        chk("reset plot", 32'(plot), 32'(0));
        chk("reset busy", 32'(busy), 32'(0));
        chk("reset done", 32'(done), 32'(0));
        $display("reset: mux_select=%0d plot=%0b busy=%0b done=%0b", mux_select, plot, busy, done);
        reset = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clock);

        // Reset in cycle 10 of a frame: 8 BLACK pixels, then silence
        run_frame("mid_reset", 1'b0, 1'b0, -1, -1, 10, 100, 8);

        // Normal frame
        run_frame("normal", 1'b0, 1'b0, -1, -1, -1, 100, 80);

        // EGG1 at the bottom-right corner: only 4 of its 16 pixels plot
        tbl[0] = pk(158, 118, 6);
        run_frame("clip", 1'b0, 1'b0, -1, -1, -1, 100, 68);
        tbl[0] = pk(10, 20, 6);

        // Game-over frame
        run_frame("game_over", 1'b1, 1'b0, -1, -1, -1, 100, 16);

        // start pulses in cycles 5 and 90 are ignored; the next frame
        // starts in cycle 92 with mux_out scrambled outside LATCH cycles
        run_frame("busy_start", 1'b0, 1'b0, 5, 90, -1, 91, 80);
        run_frame("toggle_mux", 1'b0, 1'b1, -1, -1, -1, 100, 80);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
